special_add_unpack: RTL and testbench

Parametrised special-case and unpack stage ahead of the HCORDIC floating-point adder. Accepts two packed IEEE-style operands (c, z) with an opcode and tag, classifies NaN/Inf/zero/subnormal, and either emits a final packed result with a bypass flag or unpacked operands and their exponent difference for the align/add stages. Generalises the fixed 32-bit special stage with configurable format widths, a selectable add-opcode mask, a valid/ready handshake with skid buffering, and correct Inf−Inf and subnormal-exponent handling.

---
 rtl/hcordic_pkg.sv | 40 ++++
 rtl/special_add_classify.sv | 41 ++++
 rtl/special_add_unpack.sv | 134 +++++++++++++
 tb/tb_special_add_unpack.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hcordic_pkg.sv
// Shared HCORDIC definitions: opcodes, default add-path opcode mask, format width helpers
// and the canonical quiet-NaN pattern.
package hcordic_pkg;

  localparam logic [3:0] OP_SIN_COS     = 4'd0;
  localparam logic [3:0] OP_SINH_COSH   = 4'd1;
  localparam logic [3:0] OP_ARCTAN      = 4'd2;
  localparam logic [3:0] OP_ARCTANH     = 4'd3;
  localparam logic [3:0] OP_EXPONENTIAL = 4'd4;
  localparam logic [3:0] OP_SQR_ROOT    = 4'd5;
  localparam logic [3:0] OP_DIVISION    = 4'd6;
  localparam logic [3:0] OP_TAN         = 4'd7;
  localparam logic [3:0] OP_TANH        = 4'd8;
  localparam logic [3:0] OP_NAT_LOG     = 4'd9;
  localparam logic [3:0] OP_HYPOTENUSE  = 4'd10;
  localparam logic [3:0] OP_PRE_PROCESS = 4'd11;

  localparam logic [15:0] ADD_OPS_DEFAULT = (16'h0001 << OP_SQR_ROOT) | (16'h0001 << OP_NAT_LOG);

  // Packed operand width: sign + exponent + stored mantissa.
  function automatic int calc_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Unpacked width: sign + exponent + hidden bit + mantissa + three guard bits.
  function automatic int calc_u(input int exp_w, input int man_w);
    return exp_w + man_w + 5;
  endfunction

  // Canonical qNaN: sign set, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = '0;
    w[exp_w + man_w] = 1'b1;
    for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
    w[man_w - 1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/special_add_classify.sv
// Combinational classifier for one packed operand: NaN/Inf/zero/subnormal flags,
// effective exponent and the unpacked {sign, exp, hidden, mantissa, 3'b000} word.
module special_add_classify
  import hcordic_pkg::*;
#(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int W     = calc_w(EXP_W, MAN_W),
  localparam int U     = calc_u(EXP_W, MAN_W)
) (
  input  logic [W-1:0]     word,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero,
  output logic             is_sub,
  output logic [EXP_W-1:0] eff_exp,
  output logic [U-1:0]     unpacked
);

  logic             sign;
  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign {sign, exp_field, man} = word;
  assign exp_ones = &exp_field;
  assign exp_zero = ~|exp_field;
  assign man_zero = ~|man;

  assign is_nan  = exp_ones & ~man_zero;
  assign is_inf  = exp_ones & man_zero;
  assign is_zero = exp_zero & man_zero;
  assign is_sub  = exp_zero & ~man_zero;

  // Subnormals share the exponent of the smallest normal; only the hidden bit differs.
  assign eff_exp  = exp_zero ? EXP_W'(1) : exp_field;
  assign unpacked = {sign, eff_exp, ~exp_zero, man, 3'b000};

endmodule

// File: rtl/special_add_unpack.sv
// Special-case / unpack stage ahead of the HCORDIC adder, with output register and one skid entry.
// SPECIAL_ADD_SUBNORM_EN: defined -> subnormals unpacked; undefined -> subnormals flushed to signed zero.
module special_add_unpack
  import hcordic_pkg::*;
#(
  parameter int          EXP_W   = 8,
  parameter int          MAN_W   = 23,
  parameter int          TAG_W   = 8,
  parameter logic [15:0] ADD_OPS = ADD_OPS_DEFAULT,
  localparam int         W       = calc_w(EXP_W, MAN_W),
  localparam int         U       = calc_u(EXP_W, MAN_W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [W-1:0]     cin,
  input  logic [W-1:0]     zin,
  input  logic [W-1:0]     z_pre,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             idle_out,
  output logic [EXP_W-1:0] difference,
  output logic [U-1:0]     cout,
  output logic [U-1:0]     zout,
  output logic [W-1:0]     sout,
  output logic [3:0]       opcode_out,
  output logic [W-1:0]     z_post,
  output logic [TAG_W-1:0] tag_out
);

  localparam int           BW   = 1 + EXP_W + 2 * U + W + 4 + W + TAG_W;
  localparam logic [W-1:0] QNAN = W'(qnan_word(EXP_W, MAN_W));

  logic             c_nan, c_inf, c_is_zero, c_sub, c_zero;
  logic             z_nan, z_inf, z_is_zero, z_sub, z_zero;
  logic [EXP_W-1:0] c_eff, z_eff;
  logic [U-1:0]     c_unp, z_unp;

  special_add_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) c_cls (
    .word(cin), .is_nan(c_nan), .is_inf(c_inf), .is_zero(c_is_zero), .is_sub(c_sub),
    .eff_exp(c_eff), .unpacked(c_unp)
  );

  special_add_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) z_cls (
    .word(zin), .is_nan(z_nan), .is_inf(z_inf), .is_zero(z_is_zero), .is_sub(z_sub),
    .eff_exp(z_eff), .unpacked(z_unp)
  );

`ifdef SPECIAL_ADD_SUBNORM_EN
  logic unused_sub;
  assign unused_sub = c_sub ^ z_sub;
  assign c_zero     = c_is_zero;
  assign z_zero     = z_is_zero;
`else
  // Flush-to-zero: a subnormal keeps its sign and follows the zero cases.
  assign c_zero = c_is_zero | c_sub;
  assign z_zero = z_is_zero | z_sub;
`endif

  logic             idle_next;
  logic [EXP_W-1:0] diff_next;
  logic [U-1:0]     cout_next, zout_next;
  logic [W-1:0]     sout_next;

  always_comb begin
    idle_next = 1'b1;
    diff_next = '0;
    cout_next = {{(U-W){1'b0}}, cin};
    zout_next = {{(U-W){1'b0}}, zin};
    sout_next = zin;
    if (ADD_OPS[opcode]) begin
      diff_next = (z_eff >= c_eff) ? (z_eff - c_eff) : (c_eff - z_eff);
      if (c_nan || z_nan) begin
        sout_next = QNAN;
      end else if (c_inf && z_inf && (cin[W-1] != zin[W-1])) begin
        sout_next = QNAN;
      end else if (c_inf) begin
        sout_next = {cin[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (z_inf) begin
        sout_next = {zin[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (c_zero && z_zero) begin
        sout_next = {cin[W-1] & zin[W-1], {(W-1){1'b0}}};
      end else if (c_zero) begin
        sout_next = zin;
      end else if (z_zero) begin
        sout_next = cin;
      end else begin
        idle_next = 1'b0;
        sout_next = '0;
        cout_next = c_unp;
        zout_next = z_unp;
      end
    end
  end

  logic [BW-1:0] beat_next;
  logic [BW-1:0] out_data_reg, skid_data_reg;
  logic          out_valid_reg, skid_full_reg;
  logic          accept;

  assign beat_next = {idle_next, diff_next, cout_next, zout_next, sout_next, opcode, z_pre, tag_in};
  assign in_ready  = ~skid_full_reg;
  assign accept    = in_valid & in_ready;

  // The skid entry is always older than a newly accepted beat, so it drains first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      skid_full_reg <= 1'b0;
      out_data_reg  <= '0;
      skid_data_reg <= '0;
    end else if (!out_valid_reg || out_ready) begin
      if (skid_full_reg) begin
        out_data_reg  <= skid_data_reg;
        out_valid_reg <= 1'b1;
        if (accept) skid_data_reg <= beat_next;
        else        skid_full_reg <= 1'b0;
      end else begin
        out_valid_reg <= accept;
        if (accept) out_data_reg <= beat_next;
      end
    end else if (accept) begin
      skid_data_reg <= beat_next;
      skid_full_reg <= 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign {idle_out, difference, cout, zout, sout, opcode_out, z_post, tag_out} = out_data_reg;

endmodule

// File: tb/tb_special_add_unpack.sv
// Self-checking bench for special_add_unpack: directed vectors, a floating-point-rule model
// with a scoreboard queue, backpressure/skid stream and asynchronous reset mid-stream.
module tb_special_add_unpack;

  localparam logic [15:0] ADD_MASK = 16'h0220;
`ifdef SPECIAL_ADD_SUBNORM_EN
  localparam bit SUBNORM = 1'b1;
`else
  localparam bit SUBNORM = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] cin, zin, z_pre;
  logic [7:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic        idle_out;
  logic [7:0]  difference;
  logic [35:0] cout, zout;
  logic [31:0] sout;
  logic [3:0]  opcode_out;
  logic [31:0] z_post;
  logic [7:0]  tag_out;

  special_add_unpack dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .cin(cin), .zin(zin), .z_pre(z_pre), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .idle_out(idle_out),
    .difference(difference), .cout(cout), .zout(zout), .sout(sout),
    .opcode_out(opcode_out), .z_post(z_post), .tag_out(tag_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        idle;
    logic [7:0]  diff;
    logic [35:0] cout;
    logic [35:0] zout;
    logic [31:0] sout;
    logic [3:0]  op;
    logic [31:0] zp;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Float-rule reference for 8/23 single precision.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] c, input logic [31:0] z,
                                 input logic [31:0] zp, input logic [7:0] tag);
    exp_t r;
    int ec, ez, effc, effz;
    logic [22:0] mc, mz;
    bit sc, sz, nan_c, nan_z, inf_c, inf_z, zc, zz;
    r.op = op; r.zp = zp; r.tag = tag;
    r.idle = 1'b1; r.diff = 8'd0; r.sout = z;
    r.cout = 36'(c); r.zout = 36'(z);
    if (!ADD_MASK[op]) return r;
    sc = c[31]; ec = int'(c[30:23]); mc = c[22:0];
    sz = z[31]; ez = int'(z[30:23]); mz = z[22:0];
    effc = (ec == 0) ? 1 : ec;
    effz = (ez == 0) ? 1 : ez;
    r.diff = 8'((effz > effc) ? effz - effc : effc - effz);
    nan_c = (ec == 255) && (mc != 0);  inf_c = (ec == 255) && (mc == 0);
    nan_z = (ez == 255) && (mz != 0);  inf_z = (ez == 255) && (mz == 0);
    zc = (ec == 0) && ((mc == 0) || !SUBNORM);
    zz = (ez == 0) && ((mz == 0) || !SUBNORM);
    if (nan_c || nan_z || (inf_c && inf_z && sc != sz)) r.sout = 32'hFFC0_0000;
    else if (inf_c) r.sout = sc ? 32'hFF80_0000 : 32'h7F80_0000;
    else if (inf_z) r.sout = sz ? 32'hFF80_0000 : 32'h7F80_0000;
    else if (zc && zz) r.sout = (sc && sz) ? 32'h8000_0000 : 32'h0;
    else if (zc) r.sout = z;
    else if (zz) r.sout = c;
    else begin
      r.idle = 1'b0;
      r.sout = 32'h0;
      r.cout = {sc, 8'(effc), ec != 0, mc, 3'b000};
      r.zout = {sz, 8'(effz), ez != 0, mz, 3'b000};
    end
    return r;
  endfunction

  // Scoreboard bookkeeping at the active edge (pre-update values).
  always @(posedge clock) begin
    if (!reset_n) q.delete();
    else begin
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(opcode, cin, zin, z_pre, tag_in));
    end
  end

  // Compare process: the head of the queue is what must be on the outputs.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (q.size() == 0) check("unexpected_beat", 1, 0);
      else begin
        check("idle_out",   idle_out,   q[0].idle);
        check("difference", difference, q[0].diff);
        check("cout",       cout,       q[0].cout);
        check("zout",       zout,       q[0].zout);
        check("sout",       sout,       q[0].sout);
        check("opcode_out", opcode_out, q[0].op);
        check("z_post",     z_post,     q[0].zp);
        check("tag_out",    tag_out,    q[0].tag);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] c, input logic [31:0] z,
                      input logic [7:0] tag);
    bit done = 1'b0;
    opcode = op; cin = c; zin = z; z_pre = ~c; tag_in = tag; in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      done = in_ready;
      @(posedge clock);
      @(negedge clock);
    end
    in_valid = 1'b0;
    check("send_accepted", done, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 32 && q.size() != 0; i++) @(negedge clock);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_idle_out"},  idle_out,  0);
    check({tag, "_sout"},      sout,      0);
    check({tag, "_cout"},      cout,      0);
    check({tag, "_difference"}, difference, 0);
    check({tag, "_tag_out"},   tag_out,   0);
  endtask

  logic [3:0]  v_op [13] = '{4'd5, 4'd9, 4'd5, 4'd5, 4'd5, 4'd0, 4'd5, 4'd9, 4'd5, 4'd5, 4'd9, 4'd9, 4'd3};
  logic [31:0] v_c  [13] = '{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                             32'h5555_5555, 32'h7FC0_0001, 32'hC080_0000, 32'h3F80_0000, 32'hFF80_0000,
                             32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000};
  logic [31:0] v_z  [13] = '{32'h3F80_0000, 32'hFF80_0000, 32'hBF80_0000, 32'h8000_0000, 32'h3F80_0000,
                             32'h1234_5678, 32'h3F80_0000, 32'h3F00_0000, 32'h8000_0000, 32'h3F80_0000,
                             32'h7F80_0000, 32'h0040_0000, 32'hFF80_0000};

  initial begin
    exp_t m;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; cin = '0; zin = '0; z_pre = '0; tag_in = '0;
    #2 reset_n = 1'b0;
    #1 check_reset_state("reset");
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    // Hand-computed expectations pinning the model.
    m = model(4'd5, 32'h4000_0000, 32'h3F80_0000, 32'h0, 8'h0);
    check("pin_add_idle", m.idle, 0);
    check("pin_add_diff", m.diff, 8'd1);
    check("pin_add_cout", m.cout, 36'h4_0400_0000);
    check("pin_add_zout", m.zout, 36'h3_FC00_0000);
    check("pin_add_sout", m.sout, 0);
    m = model(4'd9, 32'h7F80_0000, 32'hFF80_0000, 32'h0, 8'h0);
    check("pin_infinf_sout", m.sout, 32'hFFC0_0000);
    check("pin_infinf_cout", m.cout, 36'h0_7F80_0000);
    m = model(4'd5, 32'h0000_0000, 32'hBF80_0000, 32'h0, 8'h0);
    check("pin_czero_sout", m.sout, 32'hBF80_0000);
    check("pin_czero_diff", m.diff, 8'h7E);
    m = model(4'd5, 32'h8000_0000, 32'h8000_0000, 32'h0, 8'h0);
    check("pin_negzero_sout", m.sout, 32'h8000_0000);
    m = model(4'd5, 32'h0000_0001, 32'h3F80_0000, 32'h0, 8'h0);
    if (SUBNORM) check("pin_sub_cout", m.cout, 36'h0_0800_0008);
    else         check("pin_sub_sout", m.sout, 32'h3F80_0000);
    check("pin_sub_idle", m.idle, !SUBNORM);
    m = model(4'd0, 32'h5555_5555, 32'h1234_5678, 32'hABCD_0000, 8'h5A);
    check("pin_bypass_sout", m.sout, 32'h1234_5678);
    check("pin_bypass_diff", m.diff, 0);
    check("pin_bypass_tag", m.tag, 8'h5A);

    // Directed vectors through the DUT, full throughput.
    for (int i = 0; i < 13; i++) send(v_op[i], v_c[i], v_z[i], 8'(i + 1));
    drain();

    // Backpressure: second accept lands in the skid entry.
    out_ready = 1'b0;
    send(4'd5, 32'h4040_0000, 32'h3F80_0000, 8'hA1);
    send(4'd9, 32'h4100_0000, 32'hC000_0000, 8'hA2);
    check("in_ready_after_skid", in_ready, 0);
    check("out_valid_stalled", out_valid, 1);
    check("stalled_tag", tag_out, 8'hA1);
    fork
      send(4'd5, 32'hBF00_0000, 32'h3E80_0000, 8'hA3);
      begin
        repeat (2) @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(4'd5, 32'h4040_0000, 32'h4080_0000, 8'hB1);
    send(4'd5, 32'h4080_0000, 32'h4040_0000, 8'hB2);
    #2 reset_n = 1'b0;
    #1 check_reset_state("midreset");
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(4'd9, 32'h4200_0000, 32'h3F80_0000, 8'hB3);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
